// File: rtl/scratch_bridge_pkg.sv
// scratch_bridge_pkg: response codes and FSM state types shared by the scratchpad bridge
package scratch_bridge_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_WRITE, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
endpackage

// File: rtl/axil_scratch_bridge.sv
// axil_scratch_bridge: AXI4-Lite slave for the scratchpad RAM; SCRATCH_BRIDGE_RANGE_CHK_EN enables SLVERR range checking
module axil_scratch_bridge
  import scratch_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RAM_ADDR_WIDTH = 14,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h0800_0000,
  parameter int RD_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     s_awaddr,
  input  logic                      s_awvalid,
  output logic                      s_awready,
  input  logic [DATA_WIDTH-1:0]     s_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
  input  logic                      s_wvalid,
  output logic                      s_wready,
  output logic [1:0]                s_bresp,
  output logic                      s_bvalid,
  input  logic                      s_bready,
  input  logic [ADDR_WIDTH-1:0]     s_araddr,
  input  logic                      s_arvalid,
  output logic                      s_arready,
  output logic [DATA_WIDTH-1:0]     s_rdata,
  output logic [1:0]                s_rresp,
  output logic                      s_rvalid,
  input  logic                      s_rready,
  output logic                      ram_wr_en,
  output logic [RAM_ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0]     ram_wr_data,
  output logic [DATA_WIDTH/8-1:0]   ram_wr_byte_en,
  output logic [RAM_ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]     ram_rd_data
);
  localparam int CW = $clog2(RD_LATENCY + 2);
  wr_state_t w_state, w_next;
  rd_state_t r_state, r_next;
  logic aw_full, w_full, aw_oob_q, rd_oob_q;
  logic [CW-1:0] cnt;
  logic [ADDR_WIDTH-1:0] aw_off, ar_off;
  logic aw_oob, ar_oob, aw_hs, w_hs, ar_hs, b_hs, r_hs, rd_done, unused_off;
  assign aw_off = s_awaddr - BASE_ADDR;
  assign ar_off = s_araddr - BASE_ADDR;
  assign unused_off = ^{aw_off, ar_off};
`ifdef SCRATCH_BRIDGE_RANGE_CHK_EN
  // BASE_ADDR is window-aligned, so any set bit above the window (including wrap from below) is out of range
  assign aw_oob = |aw_off[ADDR_WIDTH-1:RAM_ADDR_WIDTH+2];
  assign ar_oob = |ar_off[ADDR_WIDTH-1:RAM_ADDR_WIDTH+2];
`else
  assign aw_oob = 1'b0;
  assign ar_oob = 1'b0;
`endif
  assign s_awready = !rst && !aw_full;
  assign s_wready = !rst && !w_full;
  assign s_arready = !rst && r_state == R_IDLE && w_state != W_WRITE;
  assign s_bvalid = !rst && w_state == W_RESP;
  assign s_rvalid = !rst && r_state == R_RESP;
  assign ram_wr_en = !rst && w_state == W_WRITE && !aw_oob_q;
  assign aw_hs = s_awvalid && s_awready;
  assign w_hs = s_wvalid && s_wready;
  assign ar_hs = s_arvalid && s_arready;
  assign b_hs = s_bvalid && s_bready;
  assign r_hs = s_rvalid && s_rready;
  assign rd_done = r_state == R_WAIT && cnt == CW'(RD_LATENCY);
  // a write may start on the edge that fills its last buffer, but yields to a read being sampled or just accepted
  always_comb begin
    w_next = w_state;
    r_next = r_state;
    unique case (w_state)
      W_IDLE:  w_next = (aw_full || aw_hs) && (w_full || w_hs) && r_state != R_WAIT && !ar_hs ? W_WRITE : W_IDLE;
      W_WRITE: w_next = W_RESP;
      default: w_next = b_hs ? W_IDLE : W_RESP;
    endcase
    unique case (r_state)
      R_IDLE:  r_next = ar_hs ? R_WAIT : R_IDLE;
      R_WAIT:  r_next = rd_done ? R_RESP : R_WAIT;
      default: r_next = r_hs ? R_IDLE : R_RESP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      aw_full <= 1'b0;
      w_full <= 1'b0;
      aw_oob_q <= 1'b0;
      rd_oob_q <= 1'b0;
      cnt <= '0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      ram_wr_byte_en <= '0;
      ram_rd_addr <= '0;
      s_bresp <= RESP_OKAY;
      s_rresp <= RESP_OKAY;
      s_rdata <= '0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_oob_q <= aw_oob;
        ram_wr_addr <= aw_off[RAM_ADDR_WIDTH+1:2];
      end
      if (w_hs) begin
        w_full <= 1'b1;
        ram_wr_data <= s_wdata;
        ram_wr_byte_en <= s_wstrb;
      end
      if (w_state == W_WRITE) s_bresp <= aw_oob_q ? RESP_SLVERR : RESP_OKAY;
      if (b_hs) begin
        aw_full <= 1'b0;
        w_full <= 1'b0;
      end
      if (ar_hs) begin
        ram_rd_addr <= ar_off[RAM_ADDR_WIDTH+1:2];
        rd_oob_q <= ar_oob;
        cnt <= '0;
      end else if (r_state == R_WAIT) cnt <= cnt + CW'(1);
      if (rd_done) begin
        s_rdata <= rd_oob_q ? '0 : ram_rd_data;
        s_rresp <= rd_oob_q ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end
endmodule

// File: tb/tb_axil_scratch_bridge.sv
// tb_axil_scratch_bridge: directed self-checking bench with a 1-cycle-latency scratchpad model
module tb_axil_scratch_bridge;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0, s_rdata, ram_wr_data, ram_rd_data;
  logic [3:0] s_wstrb = '0, ram_wr_byte_en;
  logic s_awvalid = 1'b0, s_wvalid = 1'b0, s_bready = 1'b0, s_arvalid = 1'b0, s_rready = 1'b0;
  logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid, ram_wr_en;
  logic [1:0] s_bresp, s_rresp;
  logic [13:0] ram_wr_addr, ram_rd_addr;
  int errors = 0, checks = 0;
  logic [31:0] mem [0:16383];
  logic [31:0] rd_q;

  axil_scratch_bridge dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_wr_byte_en(ram_wr_byte_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  assign ram_rd_data = rd_q;
  always @(posedge clk) begin
    if (ram_wr_en)
      for (int i = 0; i < 4; i++)
        if (ram_wr_byte_en[i]) mem[ram_wr_addr][8*i +: 8] <= ram_wr_data[8*i +: 8];
    rd_q <= mem[ram_rd_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // cycle counts are relative to the handshake cycle; -1 means not seen
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                           output int we_at, output int b_at, output logic [1:0] resp,
                           output logic [13:0] wa, output logic [3:0] be);
    int t;
    s_awaddr = a; s_wdata = d; s_wstrb = st; s_awvalid = 1'b1; s_wvalid = 1'b1;
    t = 0;
    while (!(s_awready && s_wready) && t < 20) begin tick; t++; end
    tick;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    we_at = -1; b_at = -1; resp = 'x; wa = 'x; be = 'x;
    for (int c = 1; c <= 20 && b_at < 0; c++) begin
      if (ram_wr_en && we_at < 0) begin we_at = c; wa = ram_wr_addr; be = ram_wr_byte_en; end
      if (s_bvalid) begin b_at = c; resp = s_bresp; end
      else tick;
    end
    s_bready = 1'b1; tick; s_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output int r_at, output logic [31:0] d, output logic [1:0] resp);
    int t;
    s_araddr = a; s_arvalid = 1'b1;
    t = 0;
    while (!s_arready && t < 20) begin tick; t++; end
    tick;
    s_arvalid = 1'b0;
    r_at = -1; d = 'x; resp = 'x;
    for (int c = 1; c <= 20 && r_at < 0; c++) begin
      if (s_rvalid) begin r_at = c; d = s_rdata; resp = s_rresp; end
      else tick;
    end
    s_rready = 1'b1; tick; s_rready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    tick; tick;
    checks++; if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, ram_wr_en} !== 6'b0) begin errors++; $display("FAIL reset_outputs got=%b exp=000000", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, ram_wr_en}); end
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0; rst = 1'b0;
    #1;
    checks++; if ({s_awready, s_wready, s_arready} !== 3'b111) begin errors++; $display("FAIL reset_readies got=%b exp=111", {s_awready, s_wready, s_arready}); end
    checks++; if (s_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", s_rdata); end
    checks++; if ({s_bresp, s_rresp} !== 4'b0) begin errors++; $display("FAIL reset_resp got=%b exp=0000", {s_bresp, s_rresp}); end
    checks++; if ({ram_wr_addr, ram_rd_addr} !== 28'h0) begin errors++; $display("FAIL reset_ram_addr got=%h exp=0", {ram_wr_addr, ram_rd_addr}); end
    checks++; if ({ram_wr_data, ram_wr_byte_en} !== 36'h0) begin errors++; $display("FAIL reset_ram_data got=%h exp=0", {ram_wr_data, ram_wr_byte_en}); end
  endtask

  task automatic test_write_read;
    int we, b, r; logic [1:0] resp; logic [13:0] wa; logic [3:0] be; logic [31:0] d;
    axi_write(32'h0800_0010, 32'hDEAD_BEEF, 4'hF, we, b, resp, wa, be);
    checks++; if (we !== 1) begin errors++; $display("FAIL wr_en_cycle got=%0d exp=1", we); end
    checks++; if (wa !== 14'd4) begin errors++; $display("FAIL wr_addr got=%0d exp=4", wa); end
    checks++; if (be !== 4'hF) begin errors++; $display("FAIL wr_byte_en got=%h exp=f", be); end
    checks++; if (b !== 2) begin errors++; $display("FAIL bvalid_cycle got=%0d exp=2", b); end
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL bresp got=%b exp=00", resp); end
    checks++; if ({s_awready, s_wready} !== 2'b11) begin errors++; $display("FAIL aw_w_ready_after_b got=%b exp=11", {s_awready, s_wready}); end
    axi_read(32'h0800_0010, r, d, resp);
    checks++; if (r !== 3) begin errors++; $display("FAIL rvalid_cycle got=%0d exp=3", r); end
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rdata got=%h exp=deadbeef", d); end
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL rresp got=%b exp=00", resp); end
    checks++; if (s_arready !== 1'b1) begin errors++; $display("FAIL arready_after_r got=%b exp=1", s_arready); end
  endtask

  task automatic test_strobe;
    int we, b, r; logic [1:0] resp; logic [13:0] wa; logic [3:0] be; logic [31:0] d;
    axi_write(32'h0800_0012, 32'h1122_3344, 4'b0101, we, b, resp, wa, be);
    checks++; if (be !== 4'b0101) begin errors++; $display("FAIL strb_byte_en got=%b exp=0101", be); end
    checks++; if (wa !== 14'd4) begin errors++; $display("FAIL strb_addr got=%0d exp=4", wa); end
    axi_read(32'h0800_0010, r, d, resp);
    checks++; if (d !== 32'hDE22_BE44) begin errors++; $display("FAIL strb_readback got=%h exp=de22be44", d); end
  endtask

  task automatic test_w_before_aw;
    int early; early = 0;
    s_wdata = 32'h0BAD_F00D; s_wstrb = 4'hF; s_wvalid = 1'b1;
    tick;
    s_wvalid = 1'b0;
    for (int c = 1; c < 3; c++) begin early += ram_wr_en; tick; end
    s_awaddr = 32'h0800_0020; s_awvalid = 1'b1;
    early += ram_wr_en;
    checks++; if (early !== 0) begin errors++; $display("FAIL w_first_early_wr_en got=%0d exp=0", early); end
    checks++; if ({s_awready, s_wready} !== 2'b10) begin errors++; $display("FAIL w_first_readies got=%b exp=10", {s_awready, s_wready}); end
    tick;
    s_awvalid = 1'b0;
    checks++; if ({ram_wr_en, ram_wr_addr} !== {1'b1, 14'd8}) begin errors++; $display("FAIL w_first_wr got=%b/%0d exp=1/8", ram_wr_en, ram_wr_addr); end
    tick;
    checks++; if ({s_bvalid, s_bresp} !== 3'b100) begin errors++; $display("FAIL w_first_bvalid got=%b/%b exp=1/00", s_bvalid, s_bresp); end
    s_bready = 1'b1; tick; s_bready = 1'b0;
    checks++; if (s_bvalid !== 1'b0) begin errors++; $display("FAIL w_first_bvalid_clear got=%b exp=0", s_bvalid); end
  endtask

  task automatic test_collision;
    int we, b, r; logic [1:0] resp; logic [13:0] wa; logic [3:0] be; logic [31:0] d;
    axi_write(32'h0800_001C, 32'hAAAA_5555, 4'hF, we, b, resp, wa, be);
    s_araddr = 32'h0800_001C; s_arvalid = 1'b1;
    s_awaddr = 32'h0800_001C; s_wdata = 32'h1234_5678; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
    checks++; if ({s_arready, s_awready, s_wready} !== 3'b111) begin errors++; $display("FAIL coll_readies got=%b exp=111", {s_arready, s_awready, s_wready}); end
    tick;
    s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
    we = -1; r = -1;
    for (int c = 1; c <= 10; c++) begin
      if (ram_wr_en && we < 0) we = c;
      if (s_rvalid && r < 0) begin r = c; d = s_rdata; end
      tick;
    end
    checks++; if (r !== 3) begin errors++; $display("FAIL coll_rvalid_cycle got=%0d exp=3", r); end
    checks++; if (d !== 32'hAAAA_5555) begin errors++; $display("FAIL coll_old_data got=%h exp=aaaa5555", d); end
    checks++; if (we !== 4) begin errors++; $display("FAIL coll_wr_en_cycle got=%0d exp=4", we); end
    checks++; if ({s_rvalid, s_bvalid} !== 2'b11) begin errors++; $display("FAIL coll_both_pending got=%b exp=11", {s_rvalid, s_bvalid}); end
    s_rready = 1'b1; s_bready = 1'b1; tick; s_rready = 1'b0; s_bready = 1'b0;
    axi_read(32'h0800_001C, r, d, resp);
    checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL coll_new_data got=%h exp=12345678", d); end
  endtask

  task automatic test_back_to_back;
    int we, b, r; logic [1:0] resp; logic [13:0] wa; logic [3:0] be; logic [31:0] d;
    axi_write(32'h0800_0028, 32'h0000_0001, 4'hF, we, b, resp, wa, be);
    axi_write(32'h0800_002C, 32'h0000_0002, 4'hF, we, b, resp, wa, be);
    checks++; if ({we, b, wa} !== {32'd1, 32'd2, 14'd11}) begin errors++; $display("FAIL b2b_write got=%0d/%0d/%0d exp=1/2/11", we, b, wa); end
    axi_read(32'h0800_0028, r, d, resp);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL b2b_read0 got=%h exp=1", d); end
    axi_read(32'h0800_002C, r, d, resp);
    checks++; if ({r, d} !== {32'd3, 32'h2}) begin errors++; $display("FAIL b2b_read1 got=%0d/%h exp=3/2", r, d); end
  endtask

  task automatic test_range;
    int we, b, r; logic [1:0] resp; logic [13:0] wa; logic [3:0] be; logic [31:0] d;
`ifdef SCRATCH_BRIDGE_RANGE_CHK_EN
    axi_write(32'h0800_0000, 32'h0000_0055, 4'hF, we, b, resp, wa, be);
    axi_read(32'h0801_0000, r, d, resp);
    checks++; if ({r, d, resp} !== {32'd3, 32'h0, 2'b10}) begin errors++; $display("FAIL oob_read got=%0d/%h/%b exp=3/0/10", r, d, resp); end
    axi_read(32'h07FF_FFFC, r, d, resp);
    checks++; if (resp !== 2'b10) begin errors++; $display("FAIL oob_below_rresp got=%b exp=10", resp); end
    axi_write(32'h0801_0000, 32'hFFFF_FFFF, 4'hF, we, b, resp, wa, be);
    checks++; if ({we, b, resp} !== {-32'sd1, 32'd2, 2'b10}) begin errors++; $display("FAIL oob_write got=%0d/%0d/%b exp=-1/2/10", we, b, resp); end
    axi_read(32'h0800_0000, r, d, resp);
    checks++; if ({d, resp} !== {32'h55, 2'b00}) begin errors++; $display("FAIL oob_word0_intact got=%h/%b exp=55/00", d, resp); end
`else
    axi_write(32'h0801_0000, 32'hCAFE_F00D, 4'hF, we, b, resp, wa, be);
    checks++; if ({we, wa, resp} !== {32'd1, 14'd0, 2'b00}) begin errors++; $display("FAIL alias_write got=%0d/%0d/%b exp=1/0/00", we, wa, resp); end
    axi_read(32'h0800_0000, r, d, resp);
    checks++; if ({d, resp} !== {32'hCAFE_F00D, 2'b00}) begin errors++; $display("FAIL alias_read got=%h/%b exp=cafef00d/00", d, resp); end
`endif
  endtask

  task automatic test_stall_reset;
    int t, bad, seen;
    s_araddr = 32'h0800_0010; s_arvalid = 1'b1;
    tick;
    s_arvalid = 1'b0;
    t = 0;
    while (!s_rvalid && t < 10) begin tick; t++; end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (s_rvalid !== 1'b1 || s_rdata !== 32'hDE22_BE44) bad++;
      tick;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stall_hold bad_cycles=%0d exp=0 rdata=%h", bad, s_rdata); end
    s_rready = 1'b1; tick; s_rready = 1'b0;
    checks++; if (s_rvalid !== 1'b0) begin errors++; $display("FAIL stall_release got=%b exp=0", s_rvalid); end
    s_araddr = 32'h0800_0020; s_arvalid = 1'b1;
    tick;
    s_arvalid = 1'b0; rst = 1'b1;
    #1;
    checks++; if ({s_rvalid, s_arready} !== 2'b00) begin errors++; $display("FAIL rst_mid_read got=%b exp=00", {s_rvalid, s_arready}); end
    tick;
    checks++; if ({s_rvalid, s_arready} !== 2'b00) begin errors++; $display("FAIL rst_held got=%b exp=00", {s_rvalid, s_arready}); end
    rst = 1'b0;
    #1;
    checks++; if (s_arready !== 1'b1) begin errors++; $display("FAIL rst_arready_after got=%b exp=1", s_arready); end
    seen = 0;
    for (int c = 0; c < 6; c++) begin seen += s_rvalid; tick; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_dropped rvalid_cycles=%0d exp=0", seen); end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_strobe;
    test_w_before_aw;
    test_collision;
    test_back_to_back;
    test_range;
    test_stall_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
